// File: rtl/pc_fetch_unit.sv
// Program-counter fetch unit: sequences fetch addresses through BOOT/RUN/HALT,
// applying trap > redirect > sequential advance priority with alignment enforcement.
module pc_fetch_unit #(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int unsigned     C_EXT        = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            fetch_ready,
  input  logic            is_compressed,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_vector,
  input  logic            halt_req,
  input  logic            resume_req,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_seq,
  output logic            fetch_valid,
  output logic            misalign_err,
  output logic            halted
);

  typedef enum logic [1:0] {StBoot, StRun, StHalt} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            fetch_valid_q, fetch_valid_d;
  logic            misalign_q, misalign_d;

  logic [XLEN-1:0] pc_inc;
  logic [XLEN-1:0] trap_pc;
  logic [XLEN-1:0] redir_pc;
  logic            redir_misaligned;

  assign pc_inc   = ((C_EXT != 0) && is_compressed) ? XLEN'(2) : XLEN'(4);
  assign pc_seq   = pc_q + pc_inc;
  assign trap_pc  = {trap_vector[XLEN-1:2], 2'b00};
  assign redir_pc = {redirect_target[XLEN-1:1], 1'b0};
  // Without compressed support a halfword-aligned target cannot be fetched.
  assign redir_misaligned = (C_EXT == 0) && redirect_target[1];

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    misalign_d = 1'b0;
    case (state_q)
      StBoot: state_d = StRun;
      StRun: begin
        if (trap_valid) begin
          pc_d = trap_pc;
        end else if (redirect_valid) begin
          if (redir_misaligned) begin
            pc_d       = trap_pc;
            misalign_d = 1'b1;
          end else begin
            pc_d = redir_pc;
          end
        end else if (fetch_valid_q && fetch_ready) begin
          pc_d = pc_seq;
        end
        // The PC update above still lands on the edge that enters HALT.
        if (halt_req) begin
          state_d = StHalt;
        end
      end
      StHalt: begin
        if (trap_valid) begin
          pc_d    = trap_pc;
          state_d = StRun;
        end else if (resume_req) begin
          state_d = StRun;
        end
      end
      default: state_d = StBoot;
    endcase
    fetch_valid_d = (state_d == StRun);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StBoot;
      pc_q          <= RESET_VECTOR;
      fetch_valid_q <= 1'b0;
      misalign_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      fetch_valid_q <= fetch_valid_d;
      misalign_q    <= misalign_d;
    end
  end

  assign pc           = pc_q;
  assign fetch_valid  = fetch_valid_q;
  assign misalign_err = misalign_q;
  assign halted       = (state_q == StHalt);

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: one instance with compressed support, one without,
// driven from shared stimulus; expectations are queued per cycle and checked by a monitor.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        fetch_ready = 1'b0;
  logic        is_compressed = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = '0;
  logic        trap_valid = 1'b0;
  logic [31:0] trap_vector = '0;
  logic        halt_req = 1'b0;
  logic        resume_req = 1'b0;

  logic [31:0] pc0, pc_seq0, pc1, pc_seq1;
  logic        fv0, me0, hl0, fv1, me1, hl1;

  pc_fetch_unit #(.XLEN(32), .RESET_VECTOR(32'h0), .C_EXT(1)) u_dut_c (
    .clk(clk), .reset(reset), .fetch_ready(fetch_ready), .is_compressed(is_compressed),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .trap_valid(trap_valid), .trap_vector(trap_vector), .halt_req(halt_req),
    .resume_req(resume_req), .pc(pc0), .pc_seq(pc_seq0), .fetch_valid(fv0),
    .misalign_err(me0), .halted(hl0)
  );

  pc_fetch_unit #(.XLEN(32), .RESET_VECTOR(32'h0), .C_EXT(0)) u_dut_nc (
    .clk(clk), .reset(reset), .fetch_ready(fetch_ready), .is_compressed(is_compressed),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .trap_valid(trap_valid), .trap_vector(trap_vector), .halt_req(halt_req),
    .resume_req(resume_req), .pc(pc1), .pc_seq(pc_seq1), .fetch_valid(fv1),
    .misalign_err(me1), .halted(hl1)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int          due;
    bit          sel;
    logic [31:0] pc;
    logic        fv;
    logic        hl;
    logic        me;
    bit          chk_seq;
    logic [31:0] seq;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare every expectation that falls due after this edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      while (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
        exp_t e;
        logic [31:0] a_pc, a_seq;
        logic a_fv, a_hl, a_me;
        bit bad;
        e = exp_q.pop_front();
        a_pc  = e.sel ? pc1 : pc0;
        a_seq = e.sel ? pc_seq1 : pc_seq0;
        a_fv  = e.sel ? fv1 : fv0;
        a_hl  = e.sel ? hl1 : hl0;
        a_me  = e.sel ? me1 : me0;
        bad = (e.due != cyc) || (a_pc !== e.pc) || (a_fv !== e.fv) || (a_hl !== e.hl) ||
              (a_me !== e.me) || (e.chk_seq && (a_seq !== e.seq));
        checks++;
        if (bad) begin
          failures++;
          $display("FAIL %s dut%0d: got pc=%h fv=%b halted=%b mis=%b seq=%h; want pc=%h fv=%b halted=%b mis=%b seq=%h",
                   e.name, e.sel, a_pc, a_fv, a_hl, a_me, a_seq,
                   e.pc, e.fv, e.hl, e.me, e.seq);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "timeout");
  end

  task automatic expect_out(input string nm, input bit sel, input logic [31:0] epc,
                            input logic efv, input logic ehl, input logic eme);
    exp_t e;
    e.name = nm; e.due = cyc + 1; e.sel = sel; e.pc = epc;
    e.fv = efv; e.hl = ehl; e.me = eme; e.chk_seq = 1'b0; e.seq = '0;
    exp_q.push_back(e);
  endtask

  task automatic expect_seq(input string nm, input bit sel, input logic [31:0] epc,
                            input logic [31:0] eseq);
    exp_t e;
    e.name = nm; e.due = cyc + 1; e.sel = sel; e.pc = epc;
    e.fv = 1'b1; e.hl = 1'b0; e.me = 1'b0; e.chk_seq = 1'b1; e.seq = eseq;
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic rst, input logic fr, input logic ic, input logic rv,
                       input logic [31:0] rt, input logic tv, input logic [31:0] tvec,
                       input logic hr, input logic rr);
    reset = rst; fetch_ready = fr; is_compressed = ic; redirect_valid = rv;
    redirect_target = rt; trap_valid = tv; trap_vector = tvec; halt_req = hr;
    resume_req = rr;
  endtask

  initial begin
    @(negedge clk);
    //     rst fr ic rv rt            tv tvec          hr rr
    drive(1, 0, 0, 0, 32'h0,        0, 32'h0,       0, 0);
    expect_out("reset_state", 0, 32'h0, 0, 0, 0);
    expect_out("reset_state", 1, 32'h0, 0, 0, 0);
    @(negedge clk);
    drive(0, 1, 0, 0, 32'h0,        0, 32'h0,       0, 0);
    expect_out("boot_to_run", 0, 32'h0, 1, 0, 0);
    @(negedge clk);
    expect_out("seq_4", 0, 32'h4, 1, 0, 0);
    @(negedge clk);
    expect_out("seq_8", 0, 32'h8, 1, 0, 0);
    @(negedge clk);
    expect_out("seq_c", 0, 32'hC, 1, 0, 0);
    @(negedge clk);
    drive(0, 1, 1, 0, 32'h0,        0, 32'h0,       0, 0);
    expect_seq("seq_compressed", 0, 32'hE, 32'h10);
    expect_seq("seq_noc_ignores_c", 1, 32'h10, 32'h14);
    @(negedge clk);
    drive(0, 1, 0, 1, 32'h100,      0, 32'h0,       0, 0);
    expect_out("redirect_100", 0, 32'h100, 1, 0, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 32'h0,        0, 32'h0,       0, 0);
    for (int i = 0; i < 3; i++) begin
      expect_out("backpressure_hold", 0, 32'h100, 1, 0, 0);
      @(negedge clk);
    end
    drive(0, 0, 0, 1, 32'h400,      1, 32'h203,     0, 0);
    expect_out("trap_over_redirect", 0, 32'h200, 1, 0, 0);
    expect_out("trap_over_redirect", 1, 32'h200, 1, 0, 0);
    @(negedge clk);
    drive(0, 0, 0, 1, 32'h102,      0, 32'h203,     0, 0);
    expect_out("redirect_half_c", 0, 32'h102, 1, 0, 0);
    expect_out("misalign_noc", 1, 32'h200, 1, 0, 1);
    @(negedge clk);
    drive(0, 0, 0, 0, 32'h0,        0, 32'h203,     0, 0);
    expect_out("misalign_pulse_end", 1, 32'h200, 1, 0, 0);
    @(negedge clk);
    drive(0, 0, 0, 1, 32'h103,      0, 32'h203,     0, 0);
    expect_out("redirect_odd_c", 0, 32'h102, 1, 0, 0);
    @(negedge clk);
    drive(0, 0, 0, 1, 32'h40,       0, 32'h0,       0, 0);
    expect_out("redirect_40", 0, 32'h40, 1, 0, 0);
    @(negedge clk);
    drive(0, 1, 0, 0, 32'h0,        0, 32'h0,       1, 0);
    expect_out("halt_with_advance", 0, 32'h44, 0, 1, 0);
    @(negedge clk);
    drive(0, 1, 0, 1, 32'h80,       0, 32'h0,       0, 0);
    expect_out("halt_ignores_redirect", 0, 32'h44, 0, 1, 0);
    @(negedge clk);
    drive(0, 1, 0, 0, 32'h0,        0, 32'h0,       1, 1);
    expect_out("resume_wins_in_halt", 0, 32'h44, 1, 0, 0);
    @(negedge clk);
    drive(0, 0, 0, 1, 32'hFFFFFFFC, 0, 32'h0,       0, 0);
    expect_out("redirect_top", 0, 32'hFFFFFFFC, 1, 0, 0);
    expect_out("redirect_top", 1, 32'hFFFFFFFC, 1, 0, 0);
    @(negedge clk);
    drive(0, 1, 0, 0, 32'h0,        0, 32'h0,       0, 0);
    expect_out("wrap_around", 0, 32'h0, 1, 0, 0);
    expect_out("wrap_around", 1, 32'h0, 1, 0, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 32'h0,        0, 32'h0,       1, 1);
    expect_out("halt_wins_in_run", 0, 32'h0, 0, 1, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 32'h0,        1, 32'h301,     0, 0);
    expect_out("trap_leaves_halt", 0, 32'h300, 1, 0, 0);
    @(negedge clk);
    drive(1, 1, 0, 1, 32'h500,      0, 32'h0,       0, 0);
    expect_out("reset_mid_redirect", 0, 32'h0, 0, 0, 0);
    @(negedge clk);
    drive(0, 1, 0, 0, 32'h0,        0, 32'h0,       0, 0);
    expect_out("boot_after_reset", 0, 32'h0, 1, 0, 0);
    @(negedge clk);
    drive(0, 1, 0, 0, 32'h0,        0, 32'h0,       1, 0);
    expect_out("halt_again", 0, 32'h4, 0, 1, 0);
    @(negedge clk);
    drive(1, 1, 0, 0, 32'h0,        0, 32'h0,       0, 1);
    expect_out("reset_in_halt", 0, 32'h0, 0, 0, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 32'h0,        0, 32'h0,       0, 0);
    expect_out("run_after_halt_reset", 0, 32'h0, 1, 0, 0);
    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending expectations, want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
